// File: rtl/opl3_pkg.sv
// Shared constants for the OPL3 timer control slice.
// Address map, status and control bit positions.
package opl3_pkg;

  localparam int REG_TIMER_WIDTH = 8;

  localparam logic [8:0] TIMER1_ADDR     = 9'h002;
  localparam logic [8:0] TIMER2_ADDR     = 9'h003;
  localparam logic [8:0] TIMER_CTRL_ADDR = 9'h004;

  localparam int STATUS_IRQ = 7;
  localparam int STATUS_FT1 = 6;
  localparam int STATUS_FT2 = 5;

  localparam int CTRL_RST = 7;
  localparam int CTRL_MT1 = 6;
  localparam int CTRL_MT2 = 5;
  localparam int CTRL_ST2 = 1;
  localparam int CTRL_ST1 = 0;

endpackage

// File: rtl/timer_ctrl_if.sv
// Host register write bus into the timer control block.
// Bit 8 of address selects the bank.
interface timer_ctrl_if;
  logic       wr;
  logic [8:0] address;
  logic [7:0] din;

  modport master (
    output wr,
    output address,
    output din
  );

  modport slave (
    input wr,
    input address,
    input din
  );
endinterface

// File: rtl/timer_flag.sv
// Sticky overflow flag; an unmasked set beats a same-cycle clear.
// flag_d exposes the next value so status can register in step.
module timer_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  logic mask,
  output logic flag,
  output logic flag_d
);

  always_comb begin
    flag_d = (set & ~mask) | (flag & ~clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flag <= 1'b0;
    else       flag <= flag_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// OPL3 timer preset/control registers, overflow flags and IRQ.
// All outputs come straight from flops.
module timer_ctrl
  import opl3_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  timer_ctrl_if.slave                bus,
  input  logic                       timer1_overflow_pulse,
  input  logic                       timer2_overflow_pulse,
  output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
  output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
  output logic                       start_timer1,
  output logic                       start_timer2,
  output logic [7:0]                 status,
  output logic                       irq_n
);

  logic wr_t1;
  logic wr_t2;
  logic wr_ctl;
  logic rst_flags;
  logic ld_ctl;
  logic mt1;
  logic mt2;
  logic ft1;
  logic ft2;
  logic ft1_d;
  logic ft2_d;
  logic irq_d;
  logic [7:0] status_d;

  always_comb begin
    wr_t1     = bus.wr && (bus.address == TIMER1_ADDR);
    wr_t2     = bus.wr && (bus.address == TIMER2_ADDR);
    wr_ctl    = bus.wr && (bus.address == TIMER_CTRL_ADDR);
    rst_flags = wr_ctl && bus.din[CTRL_RST];
    ld_ctl    = wr_ctl && !bus.din[CTRL_RST];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer1_reg   <= '0;
      timer2_reg   <= '0;
      mt1          <= 1'b0;
      mt2          <= 1'b0;
      start_timer1 <= 1'b0;
      start_timer2 <= 1'b0;
    end else begin
      if (wr_t1) timer1_reg <= bus.din;
      if (wr_t2) timer2_reg <= bus.din;
      if (ld_ctl) begin
        mt1          <= bus.din[CTRL_MT1];
        mt2          <= bus.din[CTRL_MT2];
        start_timer2 <= bus.din[CTRL_ST2];
        start_timer1 <= bus.din[CTRL_ST1];
      end
    end
  end

  // Masks are the pre-write values, so a same-cycle mask write is too late.
  timer_flag u_ft1 (
    .clk    (clk),
    .reset  (reset),
    .set    (timer1_overflow_pulse),
    .clr    (rst_flags),
    .mask   (mt1),
    .flag   (ft1),
    .flag_d (ft1_d)
  );

  timer_flag u_ft2 (
    .clk    (clk),
    .reset  (reset),
    .set    (timer2_overflow_pulse),
    .clr    (rst_flags),
    .mask   (mt2),
    .flag   (ft2),
    .flag_d (ft2_d)
  );

  always_comb begin
    irq_d                = ft1_d | ft2_d;
    status_d             = '0;
    status_d[STATUS_IRQ] = irq_d;
    status_d[STATUS_FT1] = ft1_d;
    status_d[STATUS_FT2] = ft2_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= 8'h00;
      irq_n  <= 1'b1;
    end else begin
      status <= status_d;
      irq_n  <= ~irq_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ft1, ft2};

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl.
// Directed table, corner sequences, then random vs a reference model.
module tb_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       p1;
  logic       p2;
  logic [7:0] t1_reg;
  logic [7:0] t2_reg;
  logic       st1;
  logic       st2;
  logic [7:0] status;
  logic       irq_n;

  int n_checks = 0;
  int n_fails  = 0;

  timer_ctrl_if bus ();

  timer_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .bus                   (bus.slave),
    .timer1_overflow_pulse (p1),
    .timer2_overflow_pulse (p2),
    .timer1_reg            (t1_reg),
    .timer2_reg            (t2_reg),
    .start_timer1          (st1),
    .start_timer2          (st2),
    .status                (status),
    .irq_n                 (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] din;
    logic       p1;
    logic       p2;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       st1;
    logic       st2;
    logic [7:0] status;
    logic       irq_n;
  } vec_t;

  vec_t tbl[$];

  // Reference state: preset values, control bits, flags
  logic [7:0] m_t1, m_t2;
  logic       m_mt1, m_mt2, m_st1, m_st2, m_ft1, m_ft2;

  function automatic logic [26:0] dut_vec();
    return {t1_reg, t2_reg, st1, st2, status, irq_n};
  endfunction

  function automatic logic [26:0] pack(
    logic [7:0] t1, logic [7:0] t2, logic s1, logic s2,
    logic [7:0] stat, logic irqn);
    return {t1, t2, s1, s2, stat, irqn};
  endfunction

  function automatic logic [26:0] model_vec();
    logic irq;
    irq = m_ft1 | m_ft2;
    return pack(m_t1, m_t2, m_st1, m_st2,
                {irq, m_ft1, m_ft2, 5'b0}, ~irq);
  endfunction

  task automatic check(string name, logic [26:0] act, logic [26:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got t1=%h t2=%h st=%b%b status=%h irq_n=%b, want t1=%h t2=%h st=%b%b status=%h irq_n=%b",
               name, act[26:19], act[18:11], act[10], act[9], act[8:1], act[0],
               exp[26:19], exp[18:11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_t1 = 0; m_t2 = 0;
    m_mt1 = 0; m_mt2 = 0; m_st1 = 0; m_st2 = 0;
    m_ft1 = 0; m_ft2 = 0;
  endtask

  task automatic model_step(logic w, logic [8:0] a, logic [7:0] d,
                            logic q1, logic q2);
    logic clr, ld, n1, n2;
    clr = w && a == 9'h004 && d[7];
    ld  = w && a == 9'h004 && !d[7];
    n1  = (q1 && !m_mt1) || (m_ft1 && !clr);
    n2  = (q2 && !m_mt2) || (m_ft2 && !clr);
    if (w && a == 9'h002) m_t1 = d;
    if (w && a == 9'h003) m_t2 = d;
    if (ld) begin
      m_mt1 = d[6]; m_mt2 = d[5]; m_st2 = d[1]; m_st1 = d[0];
    end
    m_ft1 = n1;
    m_ft2 = n2;
  endtask

  task automatic cyc(logic w, logic [8:0] a, logic [7:0] d,
                     logic q1, logic q2);
    bus.wr = w; bus.address = a; bus.din = d; p1 = q1; p2 = q2;
    @(posedge clk);
    #1;
    bus.wr = 0; bus.address = 0; bus.din = 0; p1 = 0; p2 = 0;
  endtask

  task automatic add(logic w, logic [8:0] a, logic [7:0] d,
                     logic q1, logic q2, logic [7:0] t1, logic [7:0] t2,
                     logic s1, logic s2, logic [7:0] stat, logic irqn);
    vec_t v;
    v.wr = w; v.addr = a; v.din = d; v.p1 = q1; v.p2 = q2;
    v.t1 = t1; v.t2 = t2; v.st1 = s1; v.st2 = s2;
    v.status = stat; v.irq_n = irqn;
    tbl.push_back(v);
  endtask

  initial begin
    logic [8:0] addrs[7];
    logic [8:0] a;
    logic [7:0] d;
    logic       w, q1, q2;

    addrs[0] = 9'h002; addrs[1] = 9'h003; addrs[2] = 9'h004;
    addrs[3] = 9'h104; addrs[4] = 9'h102; addrs[5] = 9'h000;
    addrs[6] = 9'h005;

    add(1, 9'h002, 8'hF0, 0, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(1, 9'h004, 8'h01, 0, 0, 8'hF0, 8'h00, 1, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 1, 0, 8'hF0, 8'h00, 1, 0, 8'hC0, 0);
    add(0, 9'h000, 8'h00, 1, 0, 8'hF0, 8'h00, 1, 0, 8'hC0, 0);
    add(1, 9'h004, 8'h80, 0, 0, 8'hF0, 8'h00, 1, 0, 8'h00, 1);
    add(1, 9'h004, 8'h40, 0, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 1, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 0, 1, 8'hF0, 8'h00, 0, 0, 8'hA0, 0);
    add(1, 9'h004, 8'h80, 0, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 1, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(1, 9'h004, 8'h00, 0, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 1, 0, 8'hF0, 8'h00, 0, 0, 8'hC0, 0);
    add(1, 9'h004, 8'h80, 0, 1, 8'hF0, 8'h00, 0, 0, 8'hA0, 0);
    add(1, 9'h104, 8'h80, 0, 0, 8'hF0, 8'h00, 0, 0, 8'hA0, 0);
    add(1, 9'h102, 8'h55, 0, 0, 8'hF0, 8'h00, 0, 0, 8'hA0, 0);
    add(1, 9'h004, 8'h80, 0, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1);
    add(1, 9'h004, 8'h23, 0, 1, 8'hF0, 8'h00, 1, 1, 8'hA0, 0);
    add(1, 9'h004, 8'h80, 0, 0, 8'hF0, 8'h00, 1, 1, 8'h00, 1);
    add(0, 9'h000, 8'h00, 0, 1, 8'hF0, 8'h00, 1, 1, 8'h00, 1);
    add(1, 9'h003, 8'h33, 0, 0, 8'hF0, 8'h33, 1, 1, 8'h00, 1);
    add(1, 9'h004, 8'h5C, 0, 0, 8'hF0, 8'h33, 0, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 1, 1, 8'hF0, 8'h33, 0, 0, 8'hA0, 0);
    add(1, 9'h004, 8'h80, 1, 0, 8'hF0, 8'h33, 0, 0, 8'h00, 1);
    add(1, 9'h004, 8'h00, 0, 0, 8'hF0, 8'h33, 0, 0, 8'h00, 1);
    add(0, 9'h000, 8'h00, 1, 0, 8'hF0, 8'h33, 0, 0, 8'hC0, 0);
    add(1, 9'h004, 8'h40, 0, 0, 8'hF0, 8'h33, 0, 0, 8'hC0, 0);
    add(0, 9'h000, 8'h00, 0, 1, 8'hF0, 8'h33, 0, 0, 8'hE0, 0);

    reset = 1; p1 = 0; p2 = 0;
    bus.wr = 0; bus.address = 0; bus.din = 0;
    #12;
    check("reset_values", dut_vec(), pack(0, 0, 0, 0, 8'h00, 1));
    @(negedge clk);
    reset = 0;

    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].p1, tbl[i].p2);
      check($sformatf("vec%0d", i), dut_vec(),
            pack(tbl[i].t1, tbl[i].t2, tbl[i].st1, tbl[i].st2,
                 tbl[i].status, tbl[i].irq_n));
    end

    // Async reset between edges with status E0; pulses during reset dropped
    #2;
    reset = 1; p1 = 1; p2 = 1;
    #1;
    check("async_reset_immediate", dut_vec(), pack(0, 0, 0, 0, 8'h00, 1));
    @(posedge clk);
    #1;
    check("held_in_reset", dut_vec(), pack(0, 0, 0, 0, 8'h00, 1));
    @(negedge clk);
    reset = 0; p1 = 0; p2 = 0;
    cyc(1, 9'h002, 8'hAA, 0, 0);
    check("first_edge_after_release", dut_vec(),
          pack(8'hAA, 0, 0, 0, 8'h00, 1));

    model_reset();
    model_step(1, 9'h002, 8'hAA, 0, 0);
    for (int i = 0; i < 600; i++) begin
      w  = ($urandom_range(0, 1) == 1);
      a  = addrs[$urandom_range(0, 6)];
      d  = 8'($urandom);
      q1 = ($urandom_range(0, 3) == 0);
      q2 = ($urandom_range(0, 3) == 0);
      cyc(w, a, d, q1, q2);
      model_step(w, a, d, q1, q2);
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
